// File: rtl/cpu_defs.sv
// Shared definitions for the single-cycle CPU front end.
// Holds the default PC width, the halt sentinel word, the instruction field
// bit positions and the fetch FSM state encoding.
package cpu_defs;

  localparam int          DEF_ADDR_W     = 8;
  localparam int          DEF_IMEM_DEPTH = 256;
  localparam logic [31:0] DEF_HALT_WORD  = 32'hFFFF_FFFF;

  localparam int OPC_HI   = 31;
  localparam int OPC_LO   = 26;
  localparam int RS_HI    = 25;
  localparam int RS_LO    = 21;
  localparam int RT_HI    = 20;
  localparam int RT_LO    = 16;
  localparam int RD_HI    = 15;
  localparam int RD_LO    = 11;
  localparam int FUNCT_HI = 5;
  localparam int FUNCT_LO = 0;
  localparam int IMM_HI   = 15;
  localparam int IMM_LO   = 0;
  localparam int TGT_HI   = 25;
  localparam int TGT_LO   = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } fsm_state_t;

endpackage

// File: rtl/next_pc_sel.sv
// Next-PC selection: priority mux (jr > j/jal > taken branch > sequential)
// plus the branch adder. Stall is handled by the PC register owner.
// Ports:
//   pc_plus1     in  ADDR_W  sequential successor of the current PC
//   imm16        in  16      branch offset in words (sign-extended here)
//   target26     in  26      jump target field, low ADDR_W bits used
//   jr_target    in  32      register jump target, low ADDR_W bits used
//   branch_taken in  1       conditional branch resolved taken
//   jump         in  1       j/jal
//   jump_reg     in  1       jr
//   next_pc      out ADDR_W  selected next PC (modulo 2^ADDR_W)
module next_pc_sel
  import cpu_defs::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic [ADDR_W-1:0] pc_plus1,
  input  logic [15:0]       imm16,
  input  logic [25:0]       target26,
  input  logic [31:0]       jr_target,
  input  logic              branch_taken,
  input  logic              jump,
  input  logic              jump_reg,
  output logic [ADDR_W-1:0] next_pc
);

  // Offset is sign-extended to full width before the add so negative
  // offsets wrap naturally once the sum is truncated to the PC width.
  function automatic logic [ADDR_W-1:0] branch_target(
    input logic [ADDR_W-1:0] base,
    input logic [15:0]       off
  );
    logic signed [31:0] s_off;
    logic        [31:0] sum;
    s_off = 32'(signed'(off));
    sum   = 32'(base) + $unsigned(s_off);
    return sum[ADDR_W-1:0];
  endfunction

  // Upper target bits are deliberately dropped: the PC space is ADDR_W wide.
  logic w_unused;
  assign w_unused = ^{jr_target[31:ADDR_W], target26[25:ADDR_W]};

  always_comb begin
    next_pc = pc_plus1;
    if (jump_reg)
      next_pc = jr_target[ADDR_W-1:0];
    else if (jump)
      next_pc = target26[ADDR_W-1:0];
    else if (branch_taken)
      next_pc = branch_target(pc_plus1, imm16);
  end

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch stage of the single-cycle CPU: PC register, word-addressed
// instruction memory with a bench-side load port, load/run/halt FSM and the
// instruction field split feeding control_unit and the datapath.
// Ports:
//   clk, reset               clock, synchronous active-high reset
//   load_en/load_addr/load_data  imem write port, honoured only in IDLE
//   start                    IDLE -> RUN
//   stall                    hold PC this cycle
//   branch_taken/jump/jump_reg/jr_target  redirect controls
//   pc, pc_plus1             current PC and its successor (jal link)
//   instr_valid, halted      fetch status
//   opcode/rs/rt/rd/funct/imm16/target26  instruction fields (0 outside RUN)
module instruction_fetch
  import cpu_defs::*;
#(
  parameter int          IMEM_DEPTH = DEF_IMEM_DEPTH,
  parameter int          ADDR_W     = DEF_ADDR_W,
  parameter logic [31:0] HALT_WORD  = DEF_HALT_WORD
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [31:0]       load_data,
  input  logic              start,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic              jump,
  input  logic              jump_reg,
  input  logic [31:0]       jr_target,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus1,
  output logic              instr_valid,
  output logic              halted,
  output logic [5:0]        opcode,
  output logic [4:0]        rs,
  output logic [4:0]        rt,
  output logic [4:0]        rd,
  output logic [5:0]        funct,
  output logic [15:0]       imm16,
  output logic [25:0]       target26
);

  fsm_state_t        r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_pc, w_pc_nxt, w_pc_plus1, w_redirect_pc;
  logic [31:0]       r_imem [IMEM_DEPTH];
  logic [31:0]       w_instr, w_fields;
  logic              w_is_halt;

  assign w_pc_plus1 = r_pc + ADDR_W'(1);
  assign w_instr    = r_imem[r_pc];
  assign w_is_halt  = (w_instr == HALT_WORD);
  assign w_fields   = (r_state == ST_RUN) ? w_instr : 32'd0;

  assign pc       = r_pc;
  assign pc_plus1 = w_pc_plus1;
  assign opcode   = w_fields[OPC_HI:OPC_LO];
  assign rs       = w_fields[RS_HI:RS_LO];
  assign rt       = w_fields[RT_HI:RT_LO];
  assign rd       = w_fields[RD_HI:RD_LO];
  assign funct    = w_fields[FUNCT_HI:FUNCT_LO];
  assign imm16    = w_fields[IMM_HI:IMM_LO];
  assign target26 = w_fields[TGT_HI:TGT_LO];

  next_pc_sel #(.ADDR_W(ADDR_W)) u_next_pc_sel (
    .pc_plus1     (w_pc_plus1),
    .imm16        (w_instr[IMM_HI:IMM_LO]),
    .target26     (w_instr[TGT_HI:TGT_LO]),
    .jr_target    (jr_target),
    .branch_taken (branch_taken),
    .jump         (jump),
    .jump_reg     (jump_reg),
    .next_pc      (w_redirect_pc)
  );

  // Program memory survives reset; writes only while the CPU is idle.
  always_ff @(posedge clk) begin
    if (!reset && load_en && (r_state == ST_IDLE))
      r_imem[load_addr] <= load_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_pc    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    instr_valid = 1'b0;
    halted      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start)
          w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        // The halt word is never executed: PC freezes on it.
        if (w_is_halt) begin
          w_state_nxt = ST_HALT;
        end else begin
          instr_valid = 1'b1;
          // A stalled redirect is dropped; the datapath re-presents it.
          if (!stall)
            w_pc_nxt = w_redirect_pc;
        end
      end
      ST_HALT: begin
        halted = 1'b1;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

endmodule
